// File: rtl/add2_bist_ctrl_if.sv
// Handshake and data bundle between the add2 BIST controller and its driver.
// The slave modport is the controller side; the master modport drives start and the CUT response.
interface add2_bist_ctrl_if;
  logic       start;
  logic [4:0] cut_in;
  logic [2:0] cut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;

  modport master (
    output start, cut_out,
    input  cut_in, busy, done, pass, signature
  );

  modport slave (
    input  start, cut_out,
    output cut_in, busy, done, pass, signature
  );
endinterface

// File: rtl/add2_bist_ctrl.sv
// LFSR/MISR BIST controller for the combinational add2 circuit.
// Optional macro ADD2_BIST_ALLZERO_EN appends one all-zero pattern after the LFSR sequence.
module add2_bist_ctrl #(
  parameter int         NUM_PATTERNS = 31,
  parameter logic [4:0] LFSR_SEED    = 5'b00001,
  parameter logic [7:0] GOLDEN_SIG   = 8'h00
) (
  input  logic           clk,
  input  logic           rst_n,
  add2_bist_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  state_t     state;
  logic [4:0] lfsr;
  logic [7:0] misr;
  logic [4:0] count;
  logic [4:0] cutReg;
  logic       busyReg;
  logic       doneReg;
  logic       passReg;
  logic       lastPattern;
`ifdef ADD2_BIST_ALLZERO_EN
  logic       zeroPhase;
`endif

  function automatic logic [4:0] lfsrNext(input logic [4:0] l);
    return {l[3:0], l[4] ^ l[2]};
  endfunction

  function automatic logic [7:0] misrNext(input logic [7:0] m, input logic [2:0] r);
    logic fb;
    logic [7:0] n;
    fb   = m[7];
    n[0] = fb ^ r[0];
    n[1] = m[0] ^ r[1];
    n[2] = m[1] ^ fb ^ r[2];
    n[3] = m[2] ^ fb;
    n[4] = m[3] ^ fb;
    n[5] = m[4];
    n[6] = m[5];
    n[7] = m[6];
    return n;
  endfunction

  assign lastPattern = ({1'b0, count} + 6'd1) == 6'(NUM_PATTERNS);

  // done/pass assert one cycle after entering DONE, giving the 2N+1 cycle done latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      misr      <= 8'h00;
      count     <= 5'd0;
      cutReg    <= 5'd0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      passReg   <= 1'b0;
`ifdef ADD2_BIST_ALLZERO_EN
      zeroPhase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= APPLY;
            lfsr      <= LFSR_SEED;
            misr      <= 8'h00;
            count     <= 5'd0;
            cutReg    <= LFSR_SEED;
            busyReg   <= 1'b1;
            doneReg   <= 1'b0;
            passReg   <= 1'b0;
`ifdef ADD2_BIST_ALLZERO_EN
            zeroPhase <= 1'b0;
`endif
          end else if (state == DONE) begin
            doneReg <= 1'b1;
            passReg <= (misr == GOLDEN_SIG);
          end
        end
        APPLY: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          misr <= misrNext(misr, bus.cut_out);
          lfsr <= lfsrNext(lfsr);
`ifdef ADD2_BIST_ALLZERO_EN
          if (zeroPhase) begin
            state   <= DONE;
            busyReg <= 1'b0;
          end else begin
            count <= count + 5'd1;
            state <= APPLY;
            if (lastPattern) begin
              zeroPhase <= 1'b1;
              cutReg    <= 5'b00000;
            end else begin
              cutReg <= lfsrNext(lfsr);
            end
          end
`else
          count <= count + 5'd1;
          if (lastPattern) begin
            state   <= DONE;
            busyReg <= 1'b0;
          end else begin
            state  <= APPLY;
            cutReg <= lfsrNext(lfsr);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cut_in    = cutReg;
  assign bus.busy      = busyReg;
  assign bus.done      = doneReg;
  assign bus.pass      = passReg;
  assign bus.signature = misr;

endmodule

// File: tb/tb_add2_bist_ctrl.sv
// Directed self-checking bench for add2_bist_ctrl with a behavioural add2 CUT.
// Honours ADD2_BIST_ALLZERO_EN for expected latency and signature.
module tb_add2_bist_ctrl;

  logic clk;
  logic rst_n;
  logic faultEn;
  int   total;
  int   bad;

  add2_bist_ctrl_if b ();
  add2_bist_ctrl_if bz ();

`ifdef ADD2_BIST_ALLZERO_EN
  localparam int EXP_LAT = 65;
`else
  localparam int EXP_LAT = 63;
`endif

  // Reference signature: walks the x^5+x^3+1 sequence through a 2-bit adder with carry-in
  function automatic logic [7:0] modelSig(input int faultPat);
    logic [4:0] l;
    logic [7:0] m;
    logic [2:0] r;
    logic       fb;
    l = 5'b00001;
    m = 8'h00;
    for (int k = 1; k <= 31; k++) begin
      r = {1'b0, l[1:0]} + {1'b0, l[3:2]} + {2'b00, l[4]};
      if (k == faultPat) r[0] = ~r[0];
      fb = m[7];
      m = {m[6], m[5], m[4], m[3] ^ fb, m[2] ^ fb, m[1] ^ fb ^ r[2], m[0] ^ r[1], fb ^ r[0]};
      l = {l[3:0], l[4] ^ l[2]};
    end
`ifdef ADD2_BIST_ALLZERO_EN
    fb = m[7];
    m = {m[6], m[5], m[4], m[3] ^ fb, m[2] ^ fb, m[1] ^ fb, m[0], fb};
`endif
    return m;
  endfunction

  localparam logic [7:0] GOLD = modelSig(0);

  function automatic logic [2:0] add2(input logic [4:0] x);
    return {1'b0, x[1:0]} + {1'b0, x[3:2]} + {2'b00, x[4]};
  endfunction

  assign b.cut_out  = add2(b.cut_in) ^ {2'b00, faultEn && (b.cut_in == 5'b10010)};
  assign bz.cut_out = 3'b000;

  add2_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(GOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  add2_bist_ctrl #(.NUM_PATTERNS(31), .LFSR_SEED(5'b00001), .GOLDEN_SIG(8'h00)) dutZero (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulseStart();
    @(negedge clk);
    b.start = 1'b1;
    @(posedge clk);
    #1 b.start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; -1 on timeout
  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (b.done) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({b.busy, b.done, b.pass} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=000", {b.busy, b.done, b.pass});
    end
    total++;
    if (b.cut_in !== 5'b00000) begin
      bad++;
      $display("[TB] FAIL reset_cut_in got=%b want=00000", b.cut_in);
    end
    total++;
    if (b.signature !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_signature got=%h want=00", b.signature);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({b.busy, b.done} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL idle_after_reset got=%b want=00", {b.busy, b.done});
    end
  endtask

  task automatic test_pattern_order();
    logic [4:0] pats [5];
    int cycles;
    pats[0] = 5'b00001;
    pats[1] = 5'b00010;
    pats[2] = 5'b00100;
    pats[3] = 5'b01001;
    pats[4] = 5'b10010;
    pulseStart();
    total++;
    if (b.busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL busy_on_start got=%b want=1", b.busy);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (b.cut_in !== pats[k]) begin
        bad++;
        $display("[TB] FAIL apply_pattern_%0d got=%b want=%b", k + 1, b.cut_in, pats[k]);
      end
      @(posedge clk);
      #1;
      total++;
      if (b.cut_in !== pats[k]) begin
        bad++;
        $display("[TB] FAIL capture_hold_%0d got=%b want=%b", k + 1, b.cut_in, pats[k]);
      end
      @(posedge clk);
      #1;
    end
    waitDone(cycles);
    total++;
    if (b.done !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pattern_run_done got=%b want=1", b.done);
    end
  endtask

  task automatic test_latency_pass();
    int cycles;
    pulseStart();
    total++;
    if ({b.done, b.pass} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL restart_clears got=%b want=00", {b.done, b.pass});
    end
    waitDone(cycles);
    total++;
    if (cycles !== EXP_LAT) begin
      bad++;
      $display("[TB] FAIL done_latency got=%0d want=%0d", cycles, EXP_LAT);
    end
    total++;
    if (b.signature !== GOLD) begin
      bad++;
      $display("[TB] FAIL golden_signature got=%h want=%h", b.signature, GOLD);
    end
    total++;
    if (b.pass !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pass_fault_free got=%b want=1", b.pass);
    end
    total++;
    if (b.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_in_done got=%b want=0", b.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({b.done, b.signature} !== {1'b1, GOLD}) begin
      bad++;
      $display("[TB] FAIL done_hold got=%b/%h want=1/%h", b.done, b.signature, GOLD);
    end
  endtask

  task automatic test_fault();
    int cycles;
    logic [7:0] expSig;
    expSig = modelSig(5);
    faultEn = 1'b1;
    pulseStart();
    waitDone(cycles);
    faultEn = 1'b0;
    total++;
    if (b.signature !== expSig) begin
      bad++;
      $display("[TB] FAIL fault_signature got=%h want=%h", b.signature, expSig);
    end
    total++;
    if (b.signature === GOLD) begin
      bad++;
      $display("[TB] FAIL fault_not_detected got=%h want!=%h", b.signature, GOLD);
    end
    total++;
    if (b.pass !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fault_pass got=%b want=0", b.pass);
    end
  endtask

  task automatic test_restart_ignore();
    int cycles;
    pulseStart();
    total++;
    if ({b.busy, b.done, b.pass} !== 3'b100) begin
      bad++;
      $display("[TB] FAIL restart_from_done got=%b want=100", {b.busy, b.done, b.pass});
    end
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      b.start = ((c >= 6 && c < 12) || c == 21 || c == 40) ? 1'b1 : 1'b0;
      if (b.done) begin
        cycles = c;
        break;
      end
    end
    b.start = 1'b0;
    total++;
    if (cycles !== EXP_LAT) begin
      bad++;
      $display("[TB] FAIL toggled_latency got=%0d want=%0d", cycles, EXP_LAT);
    end
    total++;
    if ({b.pass, b.signature} !== {1'b1, GOLD}) begin
      bad++;
      $display("[TB] FAIL rerun_signature got=%b/%h want=1/%h", b.pass, b.signature, GOLD);
    end
  endtask

  task automatic test_reset_mid_run();
    pulseStart();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({b.busy, b.done, b.pass} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL midrun_reset_flags got=%b want=000", {b.busy, b.done, b.pass});
    end
    total++;
    if ({b.cut_in, b.signature} !== 13'd0) begin
      bad++;
      $display("[TB] FAIL midrun_reset_data got=%b/%h want=00000/00", b.cut_in, b.signature);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    total++;
    if ({b.busy, b.done, b.pass} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL no_partial_done got=%b want=000", {b.busy, b.done, b.pass});
    end
  endtask

  task automatic test_zero_response();
    int cycles;
    @(negedge clk);
    bz.start = 1'b1;
    @(posedge clk);
    #1 bz.start = 1'b0;
    cycles = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (bz.done) begin
        cycles = c;
        break;
      end
    end
    total++;
    if (cycles !== EXP_LAT) begin
      bad++;
      $display("[TB] FAIL zero_latency got=%0d want=%0d", cycles, EXP_LAT);
    end
    total++;
    if ({bz.pass, bz.signature} !== {1'b1, 8'h00}) begin
      bad++;
      $display("[TB] FAIL zero_signature got=%b/%h want=1/00", bz.pass, bz.signature);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    faultEn  = 1'b0;
    b.start  = 1'b0;
    bz.start = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_pattern_order();
    test_latency_pass();
    test_fault();
    test_restart_ignore();
    test_reset_mid_run();
    test_zero_response();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
